// File: rtl/cbc_stream_encipher_pkg.sv
// Shared widths, FSM state type and S-box helper for the CBC stream encipher.
// Imported by the cipher core and the top-level block.
package cbc_stream_encipher_pkg;

  localparam int BLK_W  = 16;
  localparam int KEY_W  = 20;
  localparam int ROUNDS = 4;

  // PRESENT 4-bit S-box, entry i at bits [4*i +: 4]
  localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic logic [3:0] sbox4(input logic [3:0] n);
    return SBOX[{n, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/cbc_stream_encipher_present_encipher.sv
// Combinational 16-bit PRESENT-style block cipher with 20-bit key.
// Ports: pt_i plaintext, key_i key, ct_o ciphertext.
module present_encipher
  import cbc_stream_encipher_pkg::*;
(
  input  logic [BLK_W-1:0] pt_i,
  input  logic [KEY_W-1:0] key_i,
  output logic [BLK_W-1:0] ct_o
);

  logic [BLK_W-1:0] x;
  logic [KEY_W-1:0] rk;

  // Each round: add top 16 key bits, S-box layer, rotate state left 5.
  // Round key is the key rotated left by 5 bits per round.
  always_comb begin
    x  = pt_i;
    rk = key_i;
    for (int r = 0; r < ROUNDS; r++) begin
      x = x ^ rk[KEY_W-1:4];
      for (int n = 0; n < BLK_W / 4; n++) begin
        x[n*4 +: 4] = sbox4(x[n*4 +: 4]);
      end
      x  = {x[10:0], x[15:11]};
      rk = {rk[14:0], rk[19:15]};
    end
    ct_o = x ^ key_i[BLK_W-1:0];
  end

endmodule

// File: rtl/cbc_stream_encipher.sv
// Streams MSG_BLOCKS plaintext blocks through a CBC chain with 1-cycle latency.
// Ports: clk, rst (async high), start/init_vec/key, in_* and out_* valid/ready
// streams, out_last, busy. Define CBC_MODE_SEL_EN to add the ecb_mode input.
module cbc_stream_encipher
  import cbc_stream_encipher_pkg::*;
#(
  parameter int MSG_BLOCKS = 8,
  parameter int CNT_W      = $clog2(MSG_BLOCKS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BLK_W-1:0] init_vec,
  input  logic [KEY_W-1:0] key,
`ifdef CBC_MODE_SEL_EN
  input  logic             ecb_mode,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [BLK_W-1:0] chain_q, chain_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic             in_xfer;
  logic             out_xfer;
  logic             last_blk;
  logic [BLK_W-1:0] e_in;
  logic [BLK_W-1:0] e_out;

`ifdef CBC_MODE_SEL_EN
  logic             ecb_q, ecb_d;
`endif

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;
  assign last_blk = (cnt_q == CNT_W'(MSG_BLOCKS - 1));

`ifdef CBC_MODE_SEL_EN
  assign e_in = ecb_q ? in_data : (chain_q ^ in_data);
`else
  assign e_in = chain_q ^ in_data;
`endif

  present_encipher u_enc (
    .pt_i  (e_in),
    .key_i (key_q),
    .ct_o  (e_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (in_xfer && last_blk) state_d = DRAIN;
      DRAIN:   if (out_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    busy      = (state_q != IDLE);
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_last  = out_last_q;
  end

  // A simultaneous input transfer overrides the output-side clear,
  // which is what keeps the stream at one block per cycle.
  always_comb begin
    chain_d     = chain_q;
    key_d       = key_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef CBC_MODE_SEL_EN
    ecb_d       = ecb_q;
`endif
    if (state_q == IDLE && start) begin
      chain_d = init_vec;
      key_d   = key;
      cnt_d   = '0;
`ifdef CBC_MODE_SEL_EN
      ecb_d   = ecb_mode;
`endif
    end
    if (in_xfer) begin
      out_data_d  = e_out;
      chain_d     = e_out;
      out_valid_d = 1'b1;
      out_last_d  = last_blk;
      cnt_d       = cnt_q + 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q     <= '0;
      key_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      chain_q     <= chain_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef CBC_MODE_SEL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ecb_q <= 1'b0;
    end else begin
      ecb_q <= ecb_d;
    end
  end
`endif

endmodule

// File: doc/cbc_stream_encipher.md
CBC_STREAM_ENCIPHER -- requirements
Module: cbc_stream_encipher

Interface
REQ-001 SHALL have parameter MSG_BLOCKS, default 8, meaning the number of 16-bit blocks per message (legal range 1..256).
REQ-002 SHALL have parameter CNT_W, default $clog2(MSG_BLOCKS+1), meaning the width of the block counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  a one-cycle pulse that begins a message; sampled only in IDLE.
REQ-006 SHALL have port init_vec  input  16  the IV, latched on accepted start.
REQ-007 SHALL have port key  input  20  the cipher key, latched on accepted start.
REQ-008 SHALL have port in_valid / in_ready  input / output  1 / 1  the plaintext handshake.
REQ-009 SHALL have port in_data  input  16  the plaintext block.
REQ-010 SHALL have port out_valid / out_ready  output / input  1 / 1  the ciphertext handshake.
REQ-011 SHALL have port out_data  output  16  the ciphertext block.
REQ-012 SHALL have port out_last  output  1  high with the final block of a message.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-015 IDLE->RUN SHALL occur on start; on that edge the block latches chain<=init_vec and key_q<=key, and sets the counter to 0.
REQ-016 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready).
REQ-017 A transfer SHALL occur when in_valid && in_ready; on it, the block computes c = E(key_q, chain ^ in_data), then sets out_data<=c, chain<=c and out_valid<=1 in the same edge (1-cycle latency).
REQ-018 On acceptance of block MSG_BLOCKS-1, the block SHALL set out_last<=1 and move RUN->DRAIN.
REQ-019 An output transfer SHALL occur when out_valid && out_ready; with no simultaneous input transfer it clears out_valid and out_last.
REQ-020 A simultaneous output transfer and input transfer SHALL keep out_valid=1 and load the new block, giving full throughput of one block per cycle.
REQ-021 DRAIN->IDLE SHALL occur on the output transfer of the last block.
REQ-022 out_data SHALL be held stable while out_valid && !out_ready.
REQ-023 start outside IDLE SHALL be ignored; key/init_vec changes after latching SHALL have no effect.
REQ-024 For MSG_BLOCKS=1, the first accepted block SHALL assert out_last.
REQ-025 The counter SHALL never wrap inside a message; it resets on every new start.

Reset
REQ-026 Reset SHALL be asynchronous and active-high.
REQ-027 During reset: state=IDLE, out_valid=0, out_last=0, out_data=0, in_ready=0, busy=0, chain=0, key_q=0, counter=0.
REQ-028 Reset mid-message SHALL abandon the message; the first post-reset message behaves identically to a fresh one.

Configuration
REQ-029 Macro CBC_MODE_SEL_EN defined: the block SHALL add input ecb_mode (1 bit), latched on start; when the latched value is 1, c = E(key_q, in_data) (chain ignored).
REQ-030 CBC_MODE_SEL_EN undefined: the port SHALL be absent and the block behaves as CBC only.

Structure
REQ-031 A shared package SHALL hold BLK_W=16, KEY_W=20 and the FSM state enum.
REQ-032 E() SHALL be one instance of the existing combinational present_encipher sub-module.

Verification
REQ-033 Bench SHALL cover: MSG_BLOCKS=8, IV=16'h1234, key=20'hABCDE, plaintext 16'h0000..16'h0007 back-to-back with out_ready=1 -> 8 outputs on consecutive cycles matching the golden CBC model, out_last only on the 8th, busy drops the cycle after.
REQ-034 Bench SHALL cover: same stimulus with out_ready toggling 1,0,0,1 -> in_ready low while stalled, out_data stable, identical ciphertext sequence.
REQ-035 Bench SHALL cover: start pulsed mid-message with a new IV=16'hFFFF -> ignored, ciphertext still chained from 16'h1234.
REQ-036 Bench SHALL cover: rst asserted after block 3 -> all outputs 0 immediately; new message with IV=16'h0001 matches the model from block 0.
REQ-037 Bench SHALL cover: CBC_MODE_SEL_EN defined, ecb_mode=1, two identical plaintexts 16'h5A5A -> identical ciphertexts; with ecb_mode=0 they differ.
REQ-038 Bench SHALL cover: MSG_BLOCKS=1, single block 16'hBEEF -> out_last=1 on the only output, return to IDLE.
